// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined ripple-carry adder
//
// Purpose:
//   Default geometry of the adder, the chunk-width helper and the
//   legality check used by pipelined_ripple_adder at elaboration time.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and stage count
//   chunk_width(w, s)              : bits added per stage (w / s)
//   cfg_legal(w, s)                : 1 when s divides w and 1 <= s <= w
//   DEFAULT_CFG_OK                 : legality of the default geometry

package adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit cfg_legal(input int w, input int s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

  localparam bit DEFAULT_CFG_OK = cfg_legal(DEFAULT_WIDTH, DEFAULT_STAGES);

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CW-bit ripple-carry adder chunk
//
// Purpose:
//   One stage's worth of addition, built from full-adder cells chained
//   through a 1-bit carry.
// Ports:
//   x, y  [CW-1:0] : operand chunks
//   ci             : carry into bit 0
//   s     [CW-1:0] : sum chunk
//   co             : carry out of bit CW-1
//   c_msb          : carry into bit CW-1 (used for signed overflow)

module rca_chunk #(
  parameter int CW = 2
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  // c[i] is the carry into bit i; c[CW] leaves the chunk.
  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    logic p;
    assign p      = x[i] ^ y[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (p & c[i]);
  end

  assign co    = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - WIDTH-bit ripple adder split into STAGES registered chunks
//
// Purpose:
//   Computes {cout, sum} = a + b + cin, one CW = WIDTH/STAGES bit chunk per
//   stage, with a register boundary after every chunk. Sustains one beat
//   per cycle and stalls cleanly under valid/ready backpressure.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid, in_ready       : operand handshake (in_ready never looks at in_valid)
//   a, b [WIDTH-1:0], cin    : operands and carry in
//   out_valid, out_ready     : result handshake
//   sum [WIDTH-1:0], cout    : registered result
//   ovf                      : signed overflow, only when ADDER_OVF_EN is defined
// Configuration:
//   ADDER_OVF_EN : adds the ovf port and the register holding carry-into-MSB

module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW     = chunk_width(WIDTH, STAGES);
  localparam bit CFG_OK = cfg_legal(WIDTH, STAGES);

  if (!CFG_OK) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Stage registers. a_q/b_q carry the operands forward so later stages can
  // pick up their (not yet added) chunk; s_q accumulates finished chunks.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  // Per-stage inputs (from the port for stage 0, from stage k-1 otherwise)
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [CW-1:0]     chunk_s [STAGES];
  logic [STAGES-1:0] co_w;
  logic [STAGES-1:0] c_msb_w;

  logic [STAGES-1:0] ld;

  // Stage k may load iff some stage at or after it is empty, or the output
  // is being consumed. Written as a reduction per bit so there is no
  // chained dependency between ld bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign ld[k] = out_ready || !(&v_q[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CW{1'b1}}) << (k * CW);

    if (k == 0) begin : g_head
      assign src_a[k] = a;
      assign src_b[k] = b;
      assign src_s[k] = '0;
      assign src_c[k] = cin;
      assign src_v[k] = in_valid;
    end else begin : g_body
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_v[k] = v_q[k-1];
    end

    rca_chunk #(
      .CW (CW)
    ) u_chunk (
      .x     (src_a[k][k*CW +: CW]),
      .y     (src_b[k][k*CW +: CW]),
      .ci    (src_c[k]),
      .s     (chunk_s[k]),
      .co    (co_w[k]),
      .c_msb (c_msb_w[k])
    );

    // Splice this stage's chunk into the sum passed through from below.
    assign nxt_s[k] = (src_s[k] & ~MASK) | (WIDTH'(chunk_s[k]) << (k * CW));
  end

  // Data registers move together with the valid bit; bubbles are loaded too,
  // which is harmless because their valid bit stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= src_v[k];
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= nxt_s[k];
          c_q[k] <= co_w[k];
        end
      end
    end
  end

`ifdef ADDER_OVF_EN
  // Overflow is registered alongside the last stage so it lines up with
  // sum/cout and holds during a stall just like they do.
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ld[STAGES-1]) begin
      ovf_q <= c_msb_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  assign ovf = ovf_q;
`endif

  // Only the last stage's carry-into-MSB is meaningful.
  logic unused_c_msb;
  assign unused_c_msb = ^c_msb_w;

  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - self-checking bench for pipelined_ripple_adder

module tb_pipelined_ripple_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
`ifdef ADDER_OVF_EN
  logic       ovf;
`endif

  logic       w_in_valid = 1'b0;
  logic       w_in_ready;
  logic [3:0] w_a = '0;
  logic [3:0] w_b = '0;
  logic       w_cin = 1'b0;
  logic       w_out_valid;
  logic       w_out_ready = 1'b1;
  logic [3:0] w_sum;
  logic       w_cout;
`ifdef ADDER_OVF_EN
  logic       w_ovf;
`endif

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(4), .STAGES(2)) dut_w4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .b         (w_b),
    .cin       (w_cin),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .sum       (w_sum),
    .cout      (w_cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (w_ovf)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  vec_t vecs [10];
  vec_t tx_q [$];
  vec_t exp_q [$];

  // Observations collected by run_stream
  int ir_low;
  int acc_at_drop;
  int held_bad;
  int held_samples;
  int gaps;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic vec_t model(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    vec_t r;
    logic [8:0] t;
    t = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
    r.a = va; r.b = vb; r.cin = vc;
    r.s = t[7:0]; r.co = t[8];
    r.ov = (va[7] == vb[7]) && (t[7] != va[7]);
    return r;
  endfunction

  // Called at a negedge; sends everything in tx_q and checks every result
  // against exp_q in order. out_ready is held low for the first 'stall' cycles.
  task automatic run_stream(input int stall, input string tag);
    int   cyc;
    int   nacc;
    int   last_emit;
    bit   held_v;
    logic [7:0] held_s;
    logic held_co;
    vec_t e;
    cyc = 0; nacc = 0; last_emit = -1; held_v = 0; held_s = '0; held_co = 1'b0;
    ir_low = 0; acc_at_drop = -1; held_bad = 0; held_samples = 0; gaps = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
      out_ready = (cyc >= stall);
      in_valid  = (tx_q.size() > 0);
      if (in_valid) begin
        a = tx_q[0].a; b = tx_q[0].b; cin = tx_q[0].cin;
      end
      #1;
      if (out_valid) begin
        if (!out_ready) begin
          held_samples++;
          if (held_v && (sum !== held_s || cout !== held_co)) held_bad++;
          held_v = 1; held_s = sum; held_co = cout;
        end else begin
          held_v = 0;
          if (exp_q.size() == 0) begin
            chk({tag, "_spurious_beat"}, 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_sum_%0h_%0h_%0d", tag, e.a, e.b, e.cin), sum, e.s);
            chk($sformatf("%s_cout_%0h_%0h_%0d", tag, e.a, e.b, e.cin), cout, e.co);
`ifdef ADDER_OVF_EN
            chk($sformatf("%s_ovf_%0h_%0h_%0d", tag, e.a, e.b, e.cin), ovf, e.ov);
`endif
            if (last_emit >= 0 && cyc != last_emit + 1) gaps++;
            last_emit = cyc;
          end
        end
      end
      if (!in_ready) begin
        ir_low++;
        if (acc_at_drop < 0) acc_at_drop = nacc;
      end
      if (in_valid && in_ready) begin
        void'(tx_q.pop_front());
        nacc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_timeout"}, (cyc < 200), 1);
  endtask

  initial begin
    int         lat;
    int         seen;
    int         cyc;
    logic [8:0] sw_tx [$];
    logic [8:0] sw_exp [$];
    logic [8:0] sv;
    logic [4:0] e5;

    // a, b, cin, sum, cout, ovf (hand-computed)
    vecs[0] = '{8'h06, 8'h03, 1'b0, 8'h09, 1'b0, 1'b0};
    vecs[1] = '{8'h09, 8'h06, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h0A, 8'h05, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
`ifdef ADDER_OVF_EN
    chk("reset_ovf", ovf, 0);
`endif

    // Single beat latency: FF + 01 -> 00, carry out
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    #1;
    chk("basic_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("basic_latency", lat, 4);
    chk("basic_sum", sum, 8'h00);
    chk("basic_cout", cout, 1);
`ifdef ADDER_OVF_EN
    chk("basic_ovf", ovf, 0);
`endif
    @(negedge clk);
    chk("basic_single_beat", out_valid, 0);

    // Table vectors streamed back-to-back
    for (int i = 0; i < 10; i++) begin
      tx_q.push_back(vecs[i]);
      exp_q.push_back(vecs[i]);
    end
    run_stream(0, "stream");
    chk("stream_in_ready_low_cycles", ir_low, 0);
    chk("stream_gaps", gaps, 0);

    // Backpressure: out_ready low for 6 cycles with continuous input
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = model(8'(8'h10 * i + 3), 8'(8'hC5 - 7 * i), i[0]);
      tx_q.push_back(v);
      exp_q.push_back(v);
    end
    run_stream(6, "bp");
    chk("bp_accepts_before_full", acc_at_drop, 4);
    chk("bp_in_ready_low_cycles", ir_low, 2);
    chk("bp_stalled_samples", held_samples, 2);
    chk("bp_held_stable", held_bad, 0);

    // Reset with two beats in flight
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(negedge clk);
    a = 8'h44; b = 8'h55; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef ADDER_OVF_EN
    chk("midrst_ovf", ovf, 0);
`endif
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_dropped_beats", seen, 0);

    // Exhaustive 4-bit sweep on the 2-stage instance with random out_ready
    for (int i = 0; i < 512; i++) sw_tx.push_back(9'(i));
    cyc = 0;
    while ((sw_tx.size() > 0 || sw_exp.size() > 0) && cyc < 5000) begin
      w_out_ready = ($urandom_range(0, 3) != 0);
      w_in_valid  = (sw_tx.size() > 0);
      if (w_in_valid) begin
        sv = sw_tx[0];
        w_a = sv[8:5]; w_b = sv[4:1]; w_cin = sv[0];
      end
      #1;
      if (w_out_valid && w_out_ready) begin
        if (sw_exp.size() == 0) begin
          chk("sweep_spurious_beat", 1, 0);
        end else begin
          sv = sw_exp.pop_front();
          e5 = {1'b0, sv[8:5]} + {1'b0, sv[4:1]} + {4'd0, sv[0]};
          chk($sformatf("sweep_%0h_%0h_%0d", sv[8:5], sv[4:1], sv[0]), {w_cout, w_sum}, e5);
`ifdef ADDER_OVF_EN
          chk($sformatf("sweep_ovf_%0h_%0h_%0d", sv[8:5], sv[4:1], sv[0]), w_ovf,
              (sv[8] == sv[4]) && (e5[3] != sv[8]));
`endif
        end
      end
      if (w_in_valid && w_in_ready) sw_exp.push_back(sw_tx.pop_front());
      @(negedge clk);
      cyc++;
    end
    w_in_valid = 1'b0;
    chk("sweep_timeout", (cyc < 5000), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
